// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU control slice.
// Opcode classes, FSM state codes and datapath mux select encodings.
package cpu_pkg;

    // Encoded opcode classes, identical to the ALU encoder output
    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_ADDU  = 4'h1,
        OP_SUB   = 4'h2,
        OP_CMP   = 4'h3,
        OP_AND   = 4'h4,
        OP_OR    = 4'h5,
        OP_XOR   = 4'h6,
        OP_MOV   = 4'h7,
        OP_LSH   = 4'h8,
        OP_MUL   = 4'h9,
        OP_LOAD  = 4'hA,
        OP_STOR  = 4'hB,
        OP_BCOND = 4'hC,
        OP_JCOND = 4'hD,
        OP_JAL   = 4'hE,
        OP_WAIT  = 4'hF
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam logic PC_SEL_INC   = 1'b0;
    localparam logic PC_SEL_ALU   = 1'b1;
    localparam logic REG_WSEL_ALU = 1'b0;
    localparam logic REG_WSEL_MEM = 1'b1;

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Memory handshake bundle between the control sequencer and memory.
// master: mem_req/mem_we/addr_sel out, mem_ack in; slave is the mirror.
interface cpu_ctrl_fsm_if;

    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output addr_sel,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  addr_sel,
        output mem_ack
    );

endinterface

// File: rtl/cpu_ctrl_decode.sv
// Combinational opcode-class decoder feeding the control FSM.
// in: alu_enc; out: writes_reg, writes_flags, is_branch, is_mem, is_store, is_wait.
module cpu_ctrl_decode
    import cpu_pkg::*;
(
    input  logic [3:0] alu_enc,
    output logic       writes_reg,
    output logic       writes_flags,
    output logic       is_branch,
    output logic       is_mem,
    output logic       is_store,
    output logic       is_wait
);

    always_comb begin
        writes_reg   = 1'b0;
        writes_flags = 1'b0;
        is_branch    = 1'b0;
        is_mem       = 1'b0;
        is_store     = 1'b0;
        is_wait      = 1'b0;
        unique case (alu_enc)
            OP_ADD, OP_ADDU, OP_SUB: begin
                writes_reg   = 1'b1;
                writes_flags = 1'b1;
            end
            OP_CMP: writes_flags = 1'b1;
            OP_AND, OP_OR, OP_XOR, OP_MOV, OP_LSH, OP_MUL:
                writes_reg = 1'b1;
            OP_LOAD: begin
                writes_reg = 1'b1;
                is_mem     = 1'b1;
            end
            OP_STOR: begin
                is_mem   = 1'b1;
                is_store = 1'b1;
            end
            OP_BCOND, OP_JCOND: is_branch = 1'b1;
            // JAL writes the link (PC+1) supplied on the ALU result path
            OP_JAL: begin
                is_branch  = 1'b1;
                writes_reg = 1'b1;
            end
            OP_WAIT: is_wait = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer: fetch, decode, execute/memory, WAIT halt.
// Ports: clk, reset (sync, active-low), bus (memory handshake), alu_enc, resume, strobes, instret, state_dbg.
module cpu_ctrl_fsm
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    cpu_ctrl_fsm_if.master     bus,
    input  logic [3:0]         alu_enc,
    input  logic               resume,
    output logic               ir_en,
    output logic               pc_en,
    output logic               pc_sel,
    output logic               reg_we,
    output logic               reg_wsel,
    output logic               flags_en,
    output logic               halted,
    output logic [CNT_W-1:0]   instret,
    output logic [2:0]         state_dbg
);

    if (ADDR_W < 1 || CNT_W < 1) begin : g_bad_width
        $error("cpu_ctrl_fsm: ADDR_W and CNT_W must be positive");
    end

    state_e state, state_n;

    logic writes_reg, writes_flags;
    logic is_branch, is_mem, is_store, is_wait;

    cpu_ctrl_decode u_dec (
        .alu_enc      (alu_enc),
        .writes_reg   (writes_reg),
        .writes_flags (writes_flags),
        .is_branch    (is_branch),
        .is_mem       (is_mem),
        .is_store     (is_store),
        .is_wait      (is_wait)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            instret <= '0;
        end else begin
            state <= state_n;
            // one pc_en per instruction, so this counts retirements
            if (pc_en)
                instret <= instret + CNT_W'(1);
        end
    end

    always_comb begin
        state_n      = state;
        bus.mem_req  = 1'b0;
        bus.mem_we   = 1'b0;
        bus.addr_sel = 1'b0;
        ir_en        = 1'b0;
        pc_en        = 1'b0;
        pc_sel       = PC_SEL_INC;
        reg_we       = 1'b0;
        reg_wsel     = REG_WSEL_ALU;
        flags_en     = 1'b0;
        halted       = 1'b0;
        unique case (state)
            S_IDLE: state_n = S_FETCH;
            S_FETCH: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ack) begin
                    ir_en   = 1'b1;
                    state_n = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_mem)
                    state_n = S_MEM;
                else if (is_wait)
                    state_n = S_HALT;
                else
                    state_n = S_EXEC;
            end
            S_EXEC: begin
                pc_en    = 1'b1;
                pc_sel   = is_branch ? PC_SEL_ALU : PC_SEL_INC;
                reg_we   = writes_reg;
                flags_en = writes_flags;
                state_n  = S_FETCH;
            end
            S_MEM: begin
                bus.mem_req  = 1'b1;
                bus.addr_sel = 1'b1;
                bus.mem_we   = is_store;
                if (bus.mem_ack) begin
                    pc_en   = 1'b1;
                    state_n = S_FETCH;
                    if (!is_store) begin
                        reg_we   = 1'b1;
                        reg_wsel = REG_WSEL_MEM;
                    end
                end
            end
            S_HALT: begin
                halted = 1'b1;
                // WAIT retires on release
                if (resume) begin
                    pc_en   = 1'b1;
                    state_n = S_FETCH;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign state_dbg = state;

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the 16-bit ALU datapath (ALU, register file, flags register, PC, unified instruction/data memory).
- Fetches an instruction over a req/ack memory handshake, decodes its class from the ALU's 4-bit encoded opcode, then strobes register, flag, PC and memory writes.
- Handles the WAIT halt/resume and counts retired instructions.

Parameters:
- ADDR_W, 16, PC and memory address width.
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  reset, synchronous, active-low
- mem_ack  in  1  memory completed current request (read data valid this cycle)
- alu_enc  in  4  encoded opcode from ALU encoder (ADD=0 … WAIT=F)
- resume  in  1  level; releases WAIT halt
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  write qualifier for mem_req (STOR)
- addr_sel  out  1  0 = PC addresses memory, 1 = Rsrc addresses memory
- ir_en  out  1  latch instruction register
- pc_en  out  1  update PC
- pc_sel  out  1  0 = PC+1, 1 = ALU next_address
- reg_we  out  1  register-file write
- reg_wsel  out  1  0 = ALU result, 1 = memory read data
- flags_en  out  1  latch ALU flags into flags register
- halted  out  1  in WAIT halt
- instret  out  CNT_W  retired-instruction count
- state_dbg  out  3  current state code

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, HALT=5.
- Reset: state=IDLE, instret=0. In IDLE all outputs are 0 except state_dbg=0. Reset mid-operation wins on the next edge; an in-flight mem_req drops and any late mem_ack is ignored.
- IDLE → FETCH unconditionally after 1 cycle.
- FETCH:
  - mem_req=1, mem_we=0, addr_sel=0.
  - On mem_ack: ir_en=1 (same cycle), → DECODE.
  - Otherwise stay; there is no timeout.
- DECODE (1 cycle, register-file read). Branch by alu_enc:
  - LOAD (A) or STOR (B) → MEM.
  - WAIT (F) → HALT.
  - Everything else → EXEC.
- EXEC (1 cycle), always pc_en=1, then → FETCH:
  - ADD, ADDU, SUB: reg_we=1, flags_en=1, pc_sel=0.
  - CMP: flags_en=1, reg_we=0, pc_sel=0.
  - MUL, AND, OR, XOR, MOV, LSH: reg_we=1, pc_sel=0.
  - Bcond, Jcond: pc_sel=1, reg_we=0. The ALU resolves taken/not-taken into next_address.
  - JAL: pc_sel=1, reg_we=1, reg_wsel=0 (link = PC+1 from ALU result).
- MEM:
  - mem_req=1, addr_sel=1, mem_we=1 for STOR.
  - On mem_ack: pc_en=1, pc_sel=0; for LOAD also reg_we=1, reg_wsel=1; → FETCH.
- HALT:
  - halted=1; resume is sampled only in this state, so resume asserted earlier is not remembered.
  - On resume=1: pc_en=1, pc_sel=0, → FETCH. The WAIT instruction retires here.
- Strobes are combinational from the registered state plus mem_ack/resume. mem_req and mem_we depend on state only.
- Zero-wait memory: mem_ack in the same cycle as mem_req is legal. mem_ack outside FETCH/MEM is ignored.
- Latency with zero-wait memory:
  - ALU, branch and jump instructions: 3 cycles (FETCH, DECODE, EXEC).
  - LOAD and STOR: 3 cycles (FETCH, DECODE, MEM).
  - WAIT: 3 cycles plus the halt time.
- instret increments by 1 in every cycle where pc_en=1. It wraps from 2^CNT_W−1 to 0 with no flag.
- Flags are written only by ADD, ADDU, SUB and CMP; all other instructions preserve the flags register.
- At most one of reg_we/mem_we is asserted in any cycle. pc_en is asserted at most once per instruction.

Decomposition:
- Shared package cpu_pkg:
  - 4-bit opcode-class constants (ADD…WAIT, identical to the ALU encoder codes).
  - State encoding.
  - pc_sel and reg_wsel encodings.
- One sub-module, cpu_ctrl_decode: combinational map alu_enc → {writes_reg, writes_flags, is_branch, is_mem, is_store, is_wait}. The FSM consumes these class bits.

Test Plan:
- Reset: hold reset=0 for 3 clocks with mem_ack=1.
  - Expect state_dbg=0, all strobes 0, instret=0.
  - Release reset: mem_req=1 exactly 1 cycle later.
- ADD, zero-wait: mem_ack tied 1, alu_enc=0.
  - Expect ir_en in cycle 1, reg_we=flags_en=pc_en=1 with pc_sel=0 in cycle 3.
  - Expect instret=1 after cycle 3.
- LOAD with 2 wait states: alu_enc=A, mem_ack on the 3rd MEM cycle.
  - Expect mem_req=1 and addr_sel=1 for 3 cycles.
  - Expect reg_we=reg_wsel=pc_en=1 only on the ack cycle; no flags_en.
- STOR/CMP/JAL:
  - STOR: mem_we=1, reg_we=0.
  - CMP: flags_en=1, reg_we=0.
  - JAL: pc_sel=1, reg_we=1, reg_wsel=0.
- WAIT: alu_enc=F with resume=1 pulsed in DECODE, then resume=0 for 5 cycles, then 1.
  - Expect halted=1 for 6 cycles.
  - Exit on the resume cycle with pc_en=1 and instret incremented.
- Stress:
  - Reset asserted mid-MEM with a late mem_ack: no reg_we, state=IDLE.
  - Preload instret to 16'hFFFF via 65535 NOP-class MOVs, then one more: instret=0.
